mdu_param: RTL and testbench

Parametrised multiply/divide unit for the MIPS pipeline, sitting beside the ALU in the E stage. It owns the architectural HI/LO registers and supports:
- signed/unsigned multiply and divide with configurable width and latencies;
- multiply-accumulate/subtract (madd/maddu/msub/msubu);
- defined divide-by-zero and overflow results;
- abort of an in-flight operation on exception.

It raises a stall toward D while busy.

---
 rtl/mdu_param.sv | 162 ++++++++++++++++
 tb/tb_mdu_param.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mdu_param.sv
// Multiply/divide unit beside the E-stage ALU; owns HI/LO.
// Fixed-latency ops: result computed at start, committed when the counter expires.
module mdu_param #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op_d,
  input  logic [3:0]       op_e,
  input  logic             valid_e,
  input  logic             cancel,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             stall
);

  localparam int W2   = 2 * WIDTH;
  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    temp_q, temp_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic is_mul, is_div, is_acc, is_sub, is_sgn;
  logic start, mt_ok;

  assign is_mul = (op_e == OP_MULT)  | (op_e == OP_MULTU);
  assign is_div = (op_e == OP_DIV)   | (op_e == OP_DIVU);
  assign is_acc = (op_e == OP_MADD)  | (op_e == OP_MADDU);
  assign is_sub = (op_e == OP_MSUB)  | (op_e == OP_MSUBU);
  assign is_sgn = (op_e == OP_MULT)  | (op_e == OP_MADD) |
                  (op_e == OP_MSUB);

  assign start = valid_e & ~busy & ~cancel &
                 (is_mul | is_div | is_acc | is_sub);
  assign mt_ok = valid_e & ~busy & ~cancel;

  // Multiply: sign/zero extend to 2W so the truncated product is exact.
  logic [W2-1:0] a_x, b_x, prod, hilo, mul_res;

  assign a_x  = is_sgn ? {{WIDTH{src_a[WIDTH-1]}}, src_a}
                       : {{WIDTH{1'b0}}, src_a};
  assign b_x  = is_sgn ? {{WIDTH{src_b[WIDTH-1]}}, src_b}
                       : {{WIDTH{1'b0}}, src_b};
  assign prod = a_x * b_x;
  assign hilo = {hi_q, lo_q};

  always_comb begin
    mul_res = prod;
    unique case (1'b1)
      is_acc:  mul_res = hilo + prod;
      is_sub:  mul_res = hilo - prod;
      default: mul_res = prod;
    endcase
  end

  // Divide on magnitudes; MIN_INT / -1 falls out as MIN_INT rem 0.
  logic             sdiv, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] ua, ub, ub_safe, uq, ur, q, r;
  logic [W2-1:0]    div_res;

  assign sdiv    = (op_e == OP_DIV);
  assign a_neg   = sdiv & src_a[WIDTH-1];
  assign b_neg   = sdiv & src_b[WIDTH-1];
  assign ua      = a_neg ? -src_a : src_a;
  assign ub      = b_neg ? -src_b : src_b;
  assign b_zero  = (src_b == '0);
  assign ub_safe = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : ub;
  assign uq      = ua / ub_safe;
  assign ur      = ua % ub_safe;
  assign q       = (a_neg ^ b_neg) ? -uq : uq;
  assign r       = a_neg ? -ur : ur;

  always_comb begin
    if (b_zero) div_res = {src_a, {WIDTH{1'b1}}};
    else        div_res = {r, q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      temp_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      temp_q  <= temp_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    temp_d  = temp_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          temp_d  = is_div ? div_res : mul_res;
          cnt_d   = is_div ? CW'(DIV_CYCLES)
                           : CW'(MULT_CYCLES);
        end else if (mt_ok && op_e == OP_MTHI) begin
          hi_d = src_a;
        end else if (mt_ok && op_e == OP_MTLO) begin
          lo_d = src_a;
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(1)) begin
          state_d      = S_IDLE;
          cnt_d        = '0;
          {hi_d, lo_d} = temp_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == S_RUN);
    result = '0;
    if (op_e == OP_MFHI) result = hi_q;
    if (op_e == OP_MFLO) result = lo_q;
    stall  = (busy | start) &
             (op_d >= OP_MULT) & (op_d <= OP_MSUBU);
  end

endmodule

// File: tb/tb_mdu_param.sv
// Directed bench for mdu_param: multiply, divide, accumulate,
// boundary divides, cancel, reset and stall gating.
module tb_mdu_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op_d, op_e;
  logic        valid_e, cancel;
  logic [31:0] src_a, src_b, result;
  logic        busy, stall;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdu_param #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .op_d(op_d), .op_e(op_e),
    .valid_e(valid_e), .cancel(cancel), .src_a(src_a),
    .src_b(src_b), .result(result), .busy(busy), .stall(stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    op_e = op; valid_e = 1'b1; src_a = a; src_b = b;
    tick;
    valid_e = 1'b0; op_e = 4'd0;
  endtask

  // Start an op and count the cycles busy stays high afterwards.
  task automatic run(input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int ncyc,
                     input string tag);
    int n;
    n = 0;
    issue(op, a, b);
    while (busy && n < 40) begin
      n++;
      tick;
    end
    chk(tag, n, ncyc);
  endtask

  task automatic rd(input logic [3:0] op, input logic [31:0] exp,
                    input string tag);
    op_e = op; valid_e = 1'b1;
    #1;
    chk(tag, result, exp);
    valid_e = 1'b0; op_e = 4'd0;
  endtask

  initial begin
    reset = 1'b1; op_d = 0; op_e = 0; valid_e = 0; cancel = 0;
    src_a = 0; src_b = 0;
    tick; tick;
    reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    rd(4'd5, 32'h0, "rst_hi");
    rd(4'd6, 32'h0, "rst_lo");

    op_d = 4'd6;
    op_e = 4'd1; valid_e = 1'b1;
    src_a = 32'hFFFFFFFE; src_b = 32'd3;
    #1;
    chk("mult_start_stall", stall, 1);
    chk("mult_start_busy", busy, 0);
    tick;
    valid_e = 1'b0; op_e = 4'd0;
    for (int i = 0; i < 5; i++) begin
      chk("mult_busy", busy, 1);
      chk("mult_stall", stall, 1);
      tick;
    end
    chk("mult_done_busy", busy, 0);
    chk("mult_done_stall", stall, 0);
    rd(4'd6, 32'hFFFFFFFA, "mult_lo");
    rd(4'd5, 32'hFFFFFFFF, "mult_hi");
    op_d = 4'd0;

    run(4'd4, 32'd100, 32'd7, 10, "divu_cyc");
    rd(4'd6, 32'd14, "divu_lo");
    rd(4'd5, 32'd2, "divu_hi");
    run(4'd3, 32'hFFFFFF9C, 32'd7, 10, "div_cyc");
    rd(4'd6, 32'hFFFFFFF2, "div_lo");
    rd(4'd5, 32'hFFFFFFFE, "div_hi");

    run(4'd3, 32'd5, 32'd0, 10, "div0_cyc");
    rd(4'd6, 32'hFFFFFFFF, "div0_lo");
    rd(4'd5, 32'd5, "div0_hi");
    run(4'd3, 32'h80000000, 32'hFFFFFFFF, 10, "divov_cyc");
    rd(4'd6, 32'h80000000, "divov_lo");
    rd(4'd5, 32'h0, "divov_hi");

    issue(4'd7, 32'd1, 32'd0);
    issue(4'd8, 32'hFFFFFFFF, 32'd0);
    rd(4'd5, 32'd1, "mthi");
    rd(4'd6, 32'hFFFFFFFF, "mtlo");
    run(4'd10, 32'd1, 32'd1, 5, "maddu_cyc");
    rd(4'd5, 32'd2, "maddu_hi");
    rd(4'd6, 32'd0, "maddu_lo");
    run(4'd11, 32'd2, 32'd3, 5, "msub_cyc");
    rd(4'd5, 32'd1, "msub_hi");
    rd(4'd6, 32'hFFFFFFFA, "msub_lo");

    issue(4'd1, 32'd7, 32'd9);
    tick;
    cancel = 1'b1; op_d = 4'd6;
    #1;
    chk("cancel_stall_hold", stall, 1);
    tick;
    cancel = 1'b0;
    #1;
    chk("cancel_busy", busy, 0);
    chk("cancel_stall", stall, 0);
    rd(4'd5, 32'd1, "cancel_hi");
    rd(4'd6, 32'hFFFFFFFA, "cancel_lo");

    cancel = 1'b1;
    issue(4'd1, 32'd7, 32'd9);
    cancel = 1'b0;
    chk("cancel_start_busy", busy, 0);

    op_e = 4'd1; valid_e = 1'b0; src_a = 7; src_b = 9;
    #1;
    chk("novalid_stall", stall, 0);
    tick;
    chk("novalid_busy", busy, 0);
    op_e = 4'd0;

    issue(4'd1, 32'd7, 32'd9);
    op_d = 4'd0;
    #1;
    chk("opd_nop_stall", stall, 0);
    op_d = 4'd7;
    #1;
    chk("opd_mthi_stall", stall, 1);
    op_d = 4'd6;
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_stall", stall, 0);
    rd(4'd5, 32'h0, "midrst_hi");
    rd(4'd6, 32'h0, "midrst_lo");
    tick;
    chk("midrst_busy2", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
